rns_mod_adder_pipe: RTL and testbench
=====================================

RNS_MOD_ADDER_PIPE -- requirements
Module: rns_mod_adder_pipe

Interface
REQ-001 SHALL have parameter CH, default 3: number of RNS channels (1..16).
REQ-002 SHALL have parameter W, default 3: residue/modulus width per channel (2..16).
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port mod_ld, input, 1: load new moduli from mod_in.
REQ-006 SHALL have port mod_in, input, CH*W: moduli; channel k at bits [k*W +: W].
REQ-007 SHALL have port in_valid, input, 1: operand pair offered.
REQ-008 SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-009 SHALL have port op, input, 1: 0 = add, 1 = subtract (see REQ-030).
REQ-010 SHALL have port res_a, input, CH*W: first residue vector, same packing as mod_in.
REQ-011 SHALL have port res_b, input, CH*W: second residue vector.
REQ-012 SHALL have port out_valid, output, 1: result present.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-014 SHALL have port res_out, output, CH*W: result vector, same packing.
REQ-015 SHALL have port out_err, output, CH: per-channel flag, operand >= modulus or modulus < 2.

Function
REQ-016 SHALL keep a moduli register, CH*W, written from mod_in on the clock edge where mod_ld=1.
REQ-017 SHALL accept a transaction when in_valid && in_ready.
REQ-018 SHALL apply to an accepted transaction the moduli register value of its acceptance cycle; a same-cycle mod_ld affects only later transactions.
REQ-019 SHALL be a 2-stage pipeline:
- S1 registers the raw W+1-bit sum (or difference) and the modulus per channel.
- S2 registers the corrected result.
- Latency: 2 cycles from acceptance to out_valid with no stall.
REQ-020 SHALL compute add per channel: s = a + b in W+1 bits; result = s - m if s >= m, else s.
REQ-021 SHALL set out_err[k] when a[k] >= m[k], b[k] >= m[k], or m[k] < 2; res_out[k] is still the REQ-020/030 value truncated to W bits.
REQ-022 SHALL advance each stage when the stage downstream is empty or is being drained in the same cycle.
REQ-023 SHALL drive in_ready = !(S1 full && S2 full && !out_ready), combinationally.
REQ-024 SHALL hold res_out, out_err and out_valid stable while out_valid && !out_ready.
REQ-025 SHALL sustain one transaction per cycle when out_ready is held 1.
REQ-026 SHALL never drop or duplicate a transaction under any in_valid/out_ready pattern.
REQ-027 SHALL deliver results in acceptance order.
REQ-028 SHALL clear a stage when its contents move on and nothing new enters it.

Reset
REQ-029 SHALL, while rst_n=0 (asynchronously):
- clear both stage valid bits, so out_valid=0;
- set res_out=0 and out_err=0;
- set every modulus field to 2^W-1;
- discard any in-flight transactions; in_ready=1 on the first cycle after release.

Configuration
REQ-030 SHALL, with macro RNS_SUB_EN defined, compute for op=1: d = a - b; result = d + m if a < b, else d. Mixed add/sub transactions pipeline back-to-back.
REQ-031 SHALL, without RNS_SUB_EN, ignore op, always add, and include no subtract datapath.

Verification
REQ-032 SHALL test: W=3, CH=3, mod_ld with moduli (7,5,3), a=(6,4,2), b=(5,3,2), op=0 -> res_out=(4,2,1), out_err=0, out_valid exactly 2 cycles after acceptance.
REQ-033 SHALL test, with RNS_SUB_EN: same moduli, a=(1,0,2), b=(5,3,2), op=1 -> res_out=(3,2,0).
REQ-034 SHALL test: out_ready=0 for 5 cycles with 3 transactions offered -> in_ready falls after 2 acceptances; the third is accepted after out_ready=1; results arrive in order, unchanged while stalled.
REQ-035 SHALL test: a=(7,1,1) with moduli (7,5,3) -> out_err=3'b001, res_out channel 0 = 1.
REQ-036 SHALL test: mod_ld to (5,5,5) in the same cycle as accepting a=(4,4,2), b=(4,4,2) -> result (1,3,1) under the old moduli (7,5,3); the next transaction uses (5,5,5).
REQ-037 SHALL test: rst_n low mid-stream with 2 transactions in flight -> out_valid=0 immediately; moduli read back as (7,7,7); no stale result after release.

Source files
------------

// File: rtl/rns_mod_adder_pipe.sv
// rns_mod_adder_pipe: per-channel RNS modular adder, two-stage valid/ready pipeline.
// Each channel k occupies bits [k*W +: W] of every vector port.
// Optional build macro RNS_SUB_EN adds modular subtraction selected by op=1;
// without it op is ignored and only the add datapath exists.
module rns_mod_adder_pipe #(
    parameter int CH = 3,
    parameter int W  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mod_ld,
    input  logic [CH*W-1:0] mod_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op,
    input  logic [CH*W-1:0] res_a,
    input  logic [CH*W-1:0] res_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH*W-1:0] res_out,
    output logic [CH-1:0]   out_err
);

    localparam logic [W-1:0] MTWO = W'(2);

    logic [CH*W-1:0]     modreg;
    logic                v1, v2;
    logic [CH*(W+1)-1:0] raw1, raw_n;
    logic [CH*W-1:0]     m1;
    logic [CH-1:0]       err1, err_n;
    logic [CH*W-1:0]     res2, res_n;
    logic [CH-1:0]       err2;
    logic                s1_adv, s2_adv;

`ifdef RNS_SUB_EN
    logic                op1;
`else
    logic                unused_op;
    assign unused_op = op;
`endif

    // Stage advance: S2 moves when empty or drained; S1 moves when S2 can take it.
    assign s2_adv   = !v2 || out_ready;
    assign s1_adv   = !v1 || s2_adv;
    assign in_ready = s1_adv;

    assign out_valid = v2;
    assign res_out   = res2;
    assign out_err   = err2;

    // Moduli register; a load is seen only by transactions accepted after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modreg <= '1;
        end else if (mod_ld) begin
            modreg <= mod_in;
        end
    end

    // Front end: raw W+1-bit sum (or difference) and range-error flags per channel.
    always_comb begin
        raw_n = '0;
        err_n = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            raw_n[k*(W+1) +: (W+1)] = {1'b0, res_a[k*W +: W]} + {1'b0, res_b[k*W +: W]};
`ifdef RNS_SUB_EN
            if (op) begin
                raw_n[k*(W+1) +: (W+1)] = {1'b0, res_a[k*W +: W]} - {1'b0, res_b[k*W +: W]};
            end
`endif
            err_n[k] = (res_a[k*W +: W] >= modreg[k*W +: W]) ||
                       (res_b[k*W +: W] >= modreg[k*W +: W]) ||
                       (modreg[k*W +: W] < MTWO);
        end
    end

    // S1 register: raw value, modulus snapshot of the acceptance cycle, error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            raw1 <= '0;
            m1   <= '0;
            err1 <= '0;
`ifdef RNS_SUB_EN
            op1  <= 1'b0;
`endif
        end else if (s1_adv) begin
            v1 <= in_valid;
            if (in_valid) begin
                raw1 <= raw_n;
                m1   <= modreg;
                err1 <= err_n;
`ifdef RNS_SUB_EN
                op1  <= op;
`endif
            end
        end
    end

    // Correction: subtract m once for an add overflow, add m back for a subtract borrow.
    always_comb begin : corr
        logic [W:0] s;
        logic [W:0] mx;
        s     = '0;
        mx    = '0;
        res_n = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            s  = raw1[k*(W+1) +: (W+1)];
            mx = {1'b0, m1[k*W +: W]};
            res_n[k*W +: W] = (s >= mx) ? W'(s - mx) : s[W-1:0];
`ifdef RNS_SUB_EN
            if (op1) begin
                res_n[k*W +: W] = s[W] ? W'(s + mx) : s[W-1:0];
            end
`endif
        end
    end

    // S2 register: corrected result; contents clear when drained with nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            res2 <= '0;
            err2 <= '0;
        end else if (s2_adv) begin
            v2 <= v1;
            if (v1) begin
                res2 <= res_n;
                err2 <= err1;
            end else begin
                res2 <= '0;
                err2 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rns_mod_adder_pipe.sv
// Scoreboard bench for rns_mod_adder_pipe (CH=3, W=3), directed vectors.
// Vector notation (x0,x1,x2) lists channel 0 first.
module tb_rns_mod_adder_pipe;

    localparam int CH = 3;
    localparam int W  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mod_ld;
    logic [CH*W-1:0] mod_in;
    logic            in_valid;
    logic            in_ready;
    logic            op;
    logic [CH*W-1:0] res_a;
    logic [CH*W-1:0] res_b;
    logic            out_valid;
    logic            out_ready;
    logic [CH*W-1:0] res_out;
    logic [CH-1:0]   out_err;

    rns_mod_adder_pipe #(.CH(CH), .W(W)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mod_ld   (mod_ld),
        .mod_in   (mod_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .res_a    (res_a),
        .res_b    (res_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res_out  (res_out),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] res;
        logic [2:0] err;
        int         stamp;
        bit         chk_lat;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_accepted = 0;
    int   last_waits = 0;
    logic last_acc_oready = 1'b0;
    bit   stalled = 1'b0;
    logic [8:0] held_res;
    logic [2:0] held_err;

    function automatic logic [8:0] pk(input int x0, input int x1, input int x2);
        return {3'(x2), 3'(x1), 3'(x0)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Offer one transaction; the expected result is queued on acceptance.
    task automatic send(input logic [8:0] a, input logic [8:0] b, input logic o,
                        input logic [8:0] er, input logic [2:0] ee, input string nm,
                        input bit lat = 1'b0, input bit ld = 1'b0,
                        input logic [8:0] mv = '0);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        res_a = a;
        res_b = b;
        op = o;
        if (ld) begin
            mod_ld = 1'b1;
            mod_in = mv;
        end
        last_waits = 0;
        #1;
        while (!in_ready && last_waits < 50) begin
            @(negedge clk);
            #1;
            last_waits++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept: in_ready stayed 0, required 1 within 50 cycles", nm);
            in_valid = 1'b0;
            mod_ld = 1'b0;
            return;
        end
        e.res = er;
        e.err = ee;
        e.stamp = cyc;
        e.chk_lat = lat;
        e.name = nm;
        q.push_back(e);
        n_accepted++;
        last_acc_oready = out_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mod_ld = 1'b0;
    endtask

    task automatic load_mod(input logic [8:0] mv);
        @(negedge clk);
        mod_ld = 1'b1;
        mod_in = mv;
        @(negedge clk);
        mod_ld = 1'b0;
    endtask

    // Monitor: pops on every output handshake and checks stall stability.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_res", 32'(res_out), 32'(held_res));
                check("hold_err", 32'(out_err), 32'(held_err));
            end
            stalled = out_valid && !out_ready;
            held_res = res_out;
            held_err = out_err;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got res %0h, required no output", res_out);
                end else begin
                    e = q.pop_front();
                    check({e.name, "_res"}, 32'(res_out), 32'(e.res));
                    check({e.name, "_err"}, 32'(out_err), 32'(e.err));
                    if (e.chk_lat) check({e.name, "_latency"}, 32'(cyc - e.stamp), 32'd2);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        mod_ld = 1'b0;
        mod_in = '0;
        in_valid = 1'b0;
        op = 1'b0;
        res_a = '0;
        res_b = '0;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res_out", 32'(res_out), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic add with latency check under moduli (7,5,3).
        load_mod(pk(7, 5, 3));
        send(pk(6, 4, 2), pk(5, 3, 2), 1'b0, pk(4, 2, 1), 3'b000, "add_basic", 1'b1);
        repeat (4) @(negedge clk);

        // Back-to-back burst: each must be accepted without waiting.
        send(pk(0, 0, 0), pk(0, 0, 0), 1'b0, pk(0, 0, 0), 3'b000, "b_zero");
        check("b_zero_wait", 32'(last_waits), 32'd0);
        send(pk(6, 4, 2), pk(0, 0, 0), 1'b0, pk(6, 4, 2), 3'b000, "b_below");
        check("b_below_wait", 32'(last_waits), 32'd0);
        send(pk(3, 2, 1), pk(4, 3, 2), 1'b0, pk(0, 0, 0), 3'b000, "b_equal_m");
        check("b_equal_m_wait", 32'(last_waits), 32'd0);
        send(pk(6, 4, 2), pk(6, 4, 2), 1'b0, pk(5, 3, 1), 3'b000, "b_max");
        check("b_max_wait", 32'(last_waits), 32'd0);
        send(pk(5, 1, 1), pk(1, 3, 0), 1'b0, pk(6, 4, 1), 3'b000, "b_mixed");
        check("b_mixed_wait", 32'(last_waits), 32'd0);
        repeat (4) @(negedge clk);

        // Stall: out_ready low for 5 cycles, 3 transactions offered.
        @(negedge clk);
        out_ready = 1'b0;
        base = n_accepted;
        fork
            begin
                send(pk(1, 2, 0), pk(1, 2, 0), 1'b0, pk(2, 4, 0), 3'b000, "st1");
                send(pk(3, 3, 1), pk(3, 1, 1), 1'b0, pk(6, 4, 2), 3'b000, "st2");
                send(pk(6, 4, 2), pk(6, 4, 2), 1'b0, pk(5, 3, 1), 3'b000, "st3");
            end
            begin
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    #3;
                    if (!in_ready) break;
                end
                check("stall_in_ready_fell", 32'(in_ready), 32'd0);
                check("stall_accepts_before_block", 32'(n_accepted - base), 32'd2);
            end
        join
        check("stall_third_after_release", 32'(last_acc_oready), 32'd1);
        repeat (4) @(negedge clk);

        // Out-of-range operand flags its channel; result still corrected.
        send(pk(7, 1, 1), pk(1, 1, 1), 1'b0, pk(1, 2, 2), 3'b001, "err_a_ge_m");

        // Subtract (or add when the subtract build option is absent), mixed with add.
`ifdef RNS_SUB_EN
        send(pk(1, 0, 2), pk(5, 3, 2), 1'b1, pk(3, 2, 0), 3'b000, "sub_borrow");
        send(pk(6, 4, 2), pk(5, 3, 2), 1'b0, pk(4, 2, 1), 3'b000, "mix_add");
        send(pk(6, 4, 2), pk(2, 1, 1), 1'b1, pk(4, 3, 1), 3'b000, "sub_noborrow");
`else
        send(pk(1, 0, 2), pk(5, 3, 2), 1'b1, pk(6, 3, 1), 3'b000, "op_ignored1");
        send(pk(6, 4, 2), pk(5, 3, 2), 1'b0, pk(4, 2, 1), 3'b000, "mix_add");
        send(pk(6, 4, 2), pk(2, 1, 1), 1'b1, pk(1, 0, 0), 3'b000, "op_ignored2");
`endif
        repeat (4) @(negedge clk);

        // Same-cycle modulus load applies only to later transactions.
        send(pk(4, 4, 2), pk(4, 4, 2), 1'b0, pk(1, 3, 1), 3'b000, "ld_same_cycle",
             1'b0, 1'b1, pk(5, 5, 5));
        send(pk(4, 4, 2), pk(4, 4, 2), 1'b0, pk(3, 3, 4), 3'b000, "ld_next");
        repeat (4) @(negedge clk);

        // Moduli below 2 flag their channels.
        load_mod(pk(1, 0, 7));
        send(pk(0, 0, 3), pk(0, 0, 3), 1'b0, pk(0, 0, 6), 3'b011, "small_mod");
        repeat (4) @(negedge clk);

        // Reset with two transactions in flight.
        send(pk(0, 0, 1), pk(0, 0, 1), 1'b0, pk(0, 0, 2), 3'b011, "inflight1");
        send(pk(0, 0, 2), pk(0, 0, 2), 1'b0, pk(0, 0, 4), 3'b011, "inflight2");
        #2;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_res_out", 32'(res_out), 32'd0);
        check("reset_out_err", 32'(out_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("no_stale_valid", 32'(out_valid), 32'd0);
        end
        send(pk(3, 3, 3), pk(5, 5, 5), 1'b0, pk(1, 1, 1), 3'b000, "post_reset_mod7");

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        #3;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
